// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fb_pkg
// Desc   : Shared frame-buffer geometry and arbiter state encoding.
// Rev    : 1.0
// ============================================================================
package fb_pkg;

    localparam int FB_ADDR_W = 21;
    localparam int FB_DATA_W = 24;
    localparam int FB_DEPTH  = 2073600;

    // Bit positions of the two requesters in the rr_arb2 req/gnt vectors
    localparam int ARB_WR = 0;
    localparam int ARB_RD = 1;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } fbarb_state_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : fb_port_arbiter_if
// Desc   : Requester, clear-control and frame-buffer RAM signals of the arbiter.
// Rev    : 1.0
// ============================================================================
interface fb_port_arbiter_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_pkg::FB_DATA_W
);

    logic              clear_start;
    logic              clear_busy;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  clear_start,
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr,
        input  mem_rdata,
        output clear_busy,
        output wr_gnt,
        output rd_gnt, rd_data, rd_valid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output clear_start,
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr,
        output mem_rdata,
        input  clear_busy,
        input  wr_gnt,
        input  rd_gnt, rd_data, rd_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface : fb_port_arbiter_if
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Desc   : Two-input round-robin arbiter, combinational grant, registered flag.
// Rev    : 1.0
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    output logic      [1:0] gnt
);
    import fb_pkg::*;

    // High when the read side won the most recent grant; reset favours write
    logic last_rd_q;
    logic last_rd_d;

    always_comb begin
        gnt       = 2'b00;
        last_rd_d = last_rd_q;
        case (req)
            2'b01:   gnt[ARB_WR] = 1'b1;
            2'b10:   gnt[ARB_RD] = 1'b1;
            2'b11: begin
                if (last_rd_q) gnt[ARB_WR] = 1'b1;
                else           gnt[ARB_RD] = 1'b1;
            end
            default: gnt = 2'b00;
        endcase
        if (gnt != 2'b00) begin
            last_rd_d = gnt[ARB_RD];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fb_port_arbiter
// Desc   : Single-port frame-buffer arbiter: rasterizer write, UART read, clear.
// Rev    : 1.0
// ============================================================================
module fb_port_arbiter #(
    parameter int                   FB_ADDR_W   = fb_pkg::FB_ADDR_W,
    parameter int                   FB_DATA_W   = fb_pkg::FB_DATA_W,
    parameter int                   FB_DEPTH    = fb_pkg::FB_DEPTH,
    parameter logic [FB_DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fb_port_arbiter_if.slave  bus
);
    import fb_pkg::*;

    localparam logic [FB_ADDR_W-1:0] C_LAST_ADDR = FB_ADDR_W'(FB_DEPTH - 1);

    fbarb_state_t           state_q;
    fbarb_state_t           state_d;
    logic [FB_ADDR_W-1:0]   clr_cnt_q;
    logic [FB_ADDR_W-1:0]   clr_cnt_d;
    logic                   rd_valid_q;
    logic [FB_DATA_W-1:0]   rd_data_q;
    logic [FB_DATA_W-1:0]   rd_data_d;

    logic                   in_arb;
    logic [1:0]             arb_req;
    logic [1:0]             arb_gnt;

    logic                   mem_en;
    logic                   mem_we;
    logic [FB_ADDR_W-1:0]   mem_addr;
    logic [FB_DATA_W-1:0]   mem_wdata;

    // Masking requests outside ARB also freezes the round-robin flag during a clear
    assign in_arb  = (state_q == ARB) && !rst;
    assign arb_req = {bus.rd_req, bus.wr_req} & {2{in_arb}};

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ARB: begin
                if (bus.clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == C_LAST_ADDR) begin
                    state_d   = ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ARB;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = CLEAR_COLOR;
            end else if (arb_gnt[ARB_WR]) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = bus.wr_addr;
                mem_wdata = bus.wr_data;
            end else if (arb_gnt[ARB_RD]) begin
                mem_en    = 1'b1;
                mem_addr  = bus.rd_addr;
            end
        end
    end

    // RAM data lands one cycle after the read grant; keep the last word afterwards
    assign rd_data_d = rd_valid_q ? bus.mem_rdata : rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= arb_gnt[ARB_RD];
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.clear_busy = (state_q == CLEAR) && !rst;
    assign bus.wr_gnt     = arb_gnt[ARB_WR];
    assign bus.rd_gnt     = arb_gnt[ARB_RD];
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_d;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;

endmodule : fb_port_arbiter
`default_nettype wire

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter FB_ADDR_W, default 21, meaning frame-buffer address width.
REQ-002 SHALL have parameter FB_DATA_W, default 24, meaning pixel RGB width.
REQ-003 SHALL have parameter FB_DEPTH, default 2073600, meaning pixel count (1920x1080).
REQ-004 SHALL have parameter CLEAR_COLOR, default 24'h000000, meaning fill value written by clear.
REQ-005 SHALL have ports: clk  in  1  clock; one clock; all state on posedge clk.
REQ-006 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have ports: clear_start  in  1  pulse requesting a full-buffer clear; clear_busy  out  1  clear in progress.
REQ-008 SHALL have ports: wr_req  in  1; wr_addr  in  FB_ADDR_W; wr_data  in  FB_DATA_W; wr_gnt  out  1  (rasterizer write port).
REQ-009 SHALL have ports: rd_req  in  1; rd_addr  in  FB_ADDR_W; rd_gnt  out  1; rd_data  out  FB_DATA_W; rd_valid  out  1  (UART transmitter read port).
REQ-010 SHALL have ports: mem_en  out  1; mem_we  out  1; mem_addr  out  FB_ADDR_W; mem_wdata  out  FB_DATA_W; mem_rdata  in  FB_DATA_W  (single-port frame-buffer RAM, 1-cycle read latency).

Function
REQ-011 SHALL implement states ARB and CLEAR; reset state ARB.
REQ-012 SHALL, in ARB, grant at most one requester per cycle; grant is combinational from req in the same cycle.
REQ-013 SHALL grant a sole requester immediately; on simultaneous wr_req and rd_req, grant the one not granted most recently (round-robin flag, updated on every grant).
REQ-014 SHALL, on a write grant, drive mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in that cycle.
REQ-015 SHALL, on a read grant, drive mem_en=1, mem_we=0, mem_addr=rd_addr; assert rd_valid exactly one cycle later with rd_data=mem_rdata.
REQ-016 SHALL require requesters to hold req/addr/data stable until gnt; gnt high for one cycle completes one transfer; held req yields back-to-back transfers.
REQ-017 SHALL bound latency: with the other requester continuously requesting, a pending requester is granted within 2 cycles.
REQ-018 SHALL, on clear_start in ARB, enter CLEAR next cycle; arbitration grant in the clear_start cycle still completes.
REQ-019 SHALL, in CLEAR, write CLEAR_COLOR to address clr_cnt every cycle, clr_cnt 0..FB_DEPTH-1, then return to ARB; CLEAR lasts exactly FB_DEPTH cycles.
REQ-020 SHALL hold wr_gnt=rd_gnt=0 and clear_busy=1 throughout CLEAR; pending requests wait.
REQ-021 SHALL ignore clear_start while in CLEAR (no restart, no extension).
REQ-022 SHALL hold mem_en=0 in any cycle with no grant and not CLEAR; mem_addr/mem_wdata then hold 0.
REQ-023 SHALL size clr_cnt at FB_ADDR_W bits; terminal compare against FB_DEPTH-1, no wrap beyond.
REQ-024 SHALL never issue mem_we while rd_valid's pending read address is overwritten in the same cycle as its own read (one access per cycle guarantees this).

Reset
REQ-025 SHALL, on rst, asynchronously force state=ARB, clr_cnt=0, round-robin flag favouring write on first tie, rd_valid=0, rd_data=0.
REQ-026 SHALL drive all outputs 0 while rst is high, including clear_busy, grants and mem_*.
REQ-027 SHALL abort a clear in progress on rst; no clear resumes after release.

Structure
REQ-028 SHALL place FB_ADDR_W, FB_DATA_W, FB_DEPTH and the state enum fbarb_state_t (ARB, CLEAR) in shared package fb_pkg.
REQ-029 SHALL factor the two-input round-robin grant logic into sub-module rr_arb2 (req[1:0] in, gnt[1:0] out, clk, rst).
REQ-030 SHALL contain no RAM; the frame buffer stays external.

Verification (bench FB_DEPTH=16, ADDR_W=4)
REQ-031 SHALL check: wr_req only, addr 5, data 24'hABCDEF -> wr_gnt same cycle, mem_we=1, mem_addr=5, mem_wdata=24'hABCDEF.
REQ-032 SHALL check: rd_req only, addr 5 after REQ-031 write -> rd_gnt same cycle, rd_valid next cycle, rd_data=24'hABCDEF.
REQ-033 SHALL check: wr_req and rd_req held high 6 cycles from reset -> grants alternate W,R,W,R,W,R.
REQ-034 SHALL check: clear_start pulse -> clear_busy high exactly 16 cycles, mem_addr 0..15 with CLEAR_COLOR, no grants; reads of all addresses afterwards return CLEAR_COLOR.
REQ-035 SHALL check: second clear_start at clear cycle 8 -> no effect, busy still ends at cycle 16; wr_req held during clear -> granted first cycle after.
REQ-036 SHALL check: rst asserted at clear cycle 7 -> all outputs 0 immediately, ARB after release, clear_busy stays 0.
